// File: rtl/adder_tree_ctrl.sv
// adder_tree_ctrl: sequencer for a pipelined NUM_IN-input adder tree.
// It accepts cfg_len chunks of NUM_IN lines each and feeds them straight into
// the tree. A valid shift register, matched to the tree latency, marks which
// tree outputs to add into a per-lane accumulator. The accumulated line is then
// offered on a valid/ready output.
//
// Optional feature: define ADDER_TREE_CTRL_SAT_EN to make the per-lane
// accumulate signed and saturating. When it is not defined, the accumulate
// wraps modulo 2^DW_DATA.
//
// Ports:
//   clk, rst (async, active low)
//   start, cfg_len, busy               - run control
//   in_valid, in_ready, in_data        - chunk input (valid/ready)
//   tree_in, tree_out                  - adder tree operand / result
//   out_valid, out_ready, out_data     - accumulated result (valid/ready)
module adder_tree_ctrl #(
  parameter int unsigned NUM_IN   = 8,
  parameter int unsigned N_STACK  = 4,
  parameter int unsigned DW_DATA  = 32,
  parameter int unsigned DW_LINE  = N_STACK * DW_DATA,
  parameter int unsigned TREE_LAT = 3,
  parameter int unsigned DW_LEN   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [DW_LEN-1:0]         cfg_len,
  output logic                      busy,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_IN*DW_LINE-1:0] in_data,
  output logic [NUM_IN*DW_LINE-1:0] tree_in,
  input  logic [DW_LINE-1:0]        tree_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DW_LINE-1:0]        out_data
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // All vld bits except the oldest one. When these are clear, the last
  // tree result is either being accumulated now or has already been added.
  localparam logic [TREE_LAT-1:0] VLD_YOUNG_MASK =
    ~(TREE_LAT'(1) << (TREE_LAT - 1));

  logic [1:0]          state_q,  state_d;
  logic [DW_LEN-1:0]   len_q,    len_d;
  logic [DW_LEN-1:0]   issued_q, issued_d;
  logic [TREE_LAT-1:0] vld_q,    vld_d;
  logic [DW_LINE-1:0]  acc_q,    acc_d;
  logic [DW_LINE-1:0]  acc_sum;
  logic                accept;

  // Per-lane accumulate: signed saturating, or plain wrap.
  function automatic logic [DW_DATA-1:0] lane_add(input logic [DW_DATA-1:0] a,
                                                  input logic [DW_DATA-1:0] b);
`ifdef ADDER_TREE_CTRL_SAT_EN
    logic [DW_DATA:0] s;
    s = {a[DW_DATA-1], a} + {b[DW_DATA-1], b};
    if (s[DW_DATA] != s[DW_DATA-1]) begin
      lane_add = s[DW_DATA] ? {1'b1, {(DW_DATA-1){1'b0}}}
                            : {1'b0, {(DW_DATA-1){1'b1}}};
    end else begin
      lane_add = s[DW_DATA-1:0];
    end
`else
    lane_add = a + b;
`endif
  endfunction

  // The tree operand is taken straight from the input; the tree registers it.
  assign tree_in   = in_data;
  assign in_ready  = (state_q == S_RUN) && (issued_q < len_q);
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_data  = acc_q;

  // Lane-wise sum of the accumulator and the current tree output.
  always_comb begin
    acc_sum = '0;
    for (int i = 0; i < int'(N_STACK); i++) begin
      acc_sum[i*DW_DATA +: DW_DATA] = lane_add(acc_q[i*DW_DATA +: DW_DATA],
                                               tree_out[i*DW_DATA +: DW_DATA]);
    end
  end

  // Next-state logic for the sequencer, the valid pipe and the accumulator.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    issued_d = issued_q;
    vld_d    = (vld_q << 1) | TREE_LAT'(accept);
    acc_d    = vld_q[TREE_LAT-1] ? acc_sum : acc_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d    = cfg_len;
          issued_d = '0;
          acc_d    = '0;
          state_d  = (cfg_len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (accept) begin
          issued_d = issued_q + DW_LEN'(1);
          if (issued_d == len_q) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if ((vld_q & VLD_YOUNG_MASK) == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      issued_q <= '0;
      vld_q    <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      issued_q <= issued_d;
      vld_q    <= vld_d;
      acc_q    <= acc_d;
    end
  end

endmodule

// File: tb/tb_adder_tree_ctrl.sv
// Testbench for adder_tree_ctrl. A small 3-stage adder tree model sits
// behind tree_in/tree_out. Directed scenarios are checked against
// hand-computed sums.
module tb_adder_tree_ctrl;

  localparam int unsigned NUM_IN  = 8;
  localparam int unsigned N_STACK = 4;
  localparam int unsigned DW_DATA = 32;
  localparam int unsigned DW_LINE = 128;
  localparam int unsigned IN_W    = NUM_IN * DW_LINE;
  localparam int unsigned DW_LEN  = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [DW_LEN-1:0]  cfg_len;
  logic               busy;
  logic               in_valid;
  logic               in_ready;
  logic [IN_W-1:0]    in_data;
  logic [IN_W-1:0]    tree_in;
  logic [DW_LINE-1:0] tree_out;
  logic               out_valid;
  logic               out_ready;
  logic [DW_LINE-1:0] out_data;

  int errors = 0;
  int checks = 0;

  adder_tree_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_len   (cfg_len),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .tree_in   (tree_in),
    .tree_out  (tree_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  // Chunk whose every line carries the same four lane values.
  function automatic logic [IN_W-1:0] mk_chunk(input logic [31:0] l0, input logic [31:0] l1,
                                               input logic [31:0] l2, input logic [31:0] l3);
    logic [IN_W-1:0] c;
    for (int n = 0; n < int'(NUM_IN); n++) c[n*DW_LINE +: DW_LINE] = {l3, l2, l1, l0};
    return c;
  endfunction

  // Tree model: lane-wise sum over all lines, wrapping at 32 bits.
  function automatic logic [DW_LINE-1:0] tree_sum(input logic [IN_W-1:0] d);
    logic [DW_LINE-1:0] s;
    s = '0;
    for (int n = 0; n < int'(NUM_IN); n++)
      for (int k = 0; k < int'(N_STACK); k++)
        s[k*DW_DATA +: DW_DATA] = s[k*DW_DATA +: DW_DATA] + d[n*DW_LINE + k*DW_DATA +: DW_DATA];
    return s;
  endfunction

  logic [DW_LINE-1:0] tree_s0 = '0, tree_s1 = '0, tree_s2 = '0;
  always @(posedge clk) begin
    tree_s0 <= tree_sum(tree_in);
    tree_s1 <= tree_s0;
    tree_s2 <= tree_s1;
  end
  assign tree_out = tree_s2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [DW_LEN-1:0] len);
    cfg_len = len;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  // Offers a constant chunk until n accepts occur or the bound expires.
  task automatic feed_const(input logic [IN_W-1:0] d, input int n, output int got, output int cyc);
    in_valid = 1'b1;
    in_data  = d;
    got = 0;
    cyc = 0;
    while (got < n && cyc < 50) begin
      if (in_ready) got++;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      tick();
      cyc++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    in_data = mk_chunk(32'hA5A5_0001, 32'h0000_0002, 32'hDEAD_BEEF, 32'h1234_5678);
    #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    checks++; if (tree_in !== mk_chunk(32'hA5A5_0001, 32'h0000_0002, 32'hDEAD_BEEF, 32'h1234_5678)) begin
      errors++; $display("FAIL reset_tree_in: tree_in does not follow in_data");
    end
    in_data = '0;
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    do_start(8'd1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready: got %b want 1", in_ready); end
    in_valid = 1'b1;
    in_data  = mk_chunk(32'd1, 32'd1, 32'd1, 32'd1);
    tick();
    in_valid = 1'b0;
    in_data  = '0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL single_in_ready_after: got %b want 0", in_ready); end
    for (int c = 1; c < 4; c++) begin
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b want 0 at T+%0d", out_valid, c); end
      tick();
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid_t4: got %b want 1", out_valid); end
    checks++; if (out_data !== {4{32'd8}}) begin errors++; $display("FAIL single_data: got %h want %h", out_data, {4{32'd8}}); end
    handshake();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_fall: got %b want 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_fall: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    int got, cyc, w;
    do_start(8'd3);
    in_valid = 1'b1;
    in_data  = mk_chunk(32'd1, 32'd2, 32'd3, 32'd4);
    got = 0;
    cyc = 0;
    while (got < 3 && cyc < 50) begin
      if (in_ready) got++;
      tick();
      cyc++;
    end
    checks++; if (got !== 3 || cyc !== 3) begin errors++; $display("FAIL stream_accepts: got %0d accepts in %0d cycles want 3 in 3", got, cyc); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stream_in_ready_low: got %b want 0", in_ready); end
    in_valid = 1'b0;
    in_data  = '0;
    wait_valid(w);
    checks++; if (w !== 3) begin errors++; $display("FAIL stream_latency: got T+%0d want T+4", w + 1); end
    checks++; if (out_data !== {32'd96, 32'd72, 32'd48, 32'd24}) begin
      errors++; $display("FAIL stream_data: got %h want %h", out_data, {32'd96, 32'd72, 32'd48, 32'd24});
    end
    handshake();
  endtask

  task automatic test_bubbles();
    int n, w;
    logic [DW_LINE-1:0] exp;
    exp = {32'h0246_8AC0, 32'hFFFF_FFE0, 32'h0000_5000, 32'h0000_0050};
    do_start(8'd4);
    n = 0;
    for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
      in_valid = (cyc % 2 == 0);
      in_data  = mk_chunk(32'(n + 1), 32'(256 * (n + 1)), 32'hFFFF_FFFF, 32'h0012_3456);
      if (in_valid && in_ready) n++;
      tick();
    end
    in_valid = 1'b0;
    in_data  = '0;
    checks++; if (n !== 4) begin errors++; $display("FAIL bubble_accepts: got %0d want 4", n); end
    wait_valid(w);
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== exp) begin
        errors++; $display("FAIL bubble_hold: cycle %0d valid %b data %h want 1 %h", i, out_valid, out_data, exp);
      end
      tick();
    end
    handshake();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bubble_busy_fall: got %b want 0", busy); end
  endtask

  task automatic test_zero_len();
    in_valid = 1'b1;
    in_data  = mk_chunk(32'd7, 32'd7, 32'd7, 32'd7);
    do_start(8'd0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL zero_valid: got %b want 1", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL zero_data: got %h want 0", out_data); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL zero_in_ready: got %b want 0", in_ready); end
    handshake();
    in_valid = 1'b0;
    in_data  = '0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy_fall: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    int got, cyc, w;
    do_start(8'd3);
    feed_const(mk_chunk(32'd5, 32'd5, 32'd5, 32'd5), 3, got, cyc);
    tick();
    // One chunk has been accumulated; two are still in the tree.
    checks++; if (out_data !== {4{32'd40}}) begin errors++; $display("FAIL abort_partial: got %h want %h", out_data, {4{32'd40}}); end
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== '0) begin
      errors++; $display("FAIL abort_outputs: busy %b in_ready %b out_valid %b out_data %h want all 0", busy, in_ready, out_valid, out_data);
    end
    #2;
    rst = 1'b1;
    tick();
    do_start(8'd1);
    feed_const(mk_chunk(32'd2, 32'd2, 32'd2, 32'd2), 1, got, cyc);
    wait_valid(w);
    checks++; if (out_valid !== 1'b1 || out_data !== {4{32'd16}}) begin
      errors++; $display("FAIL abort_rerun: valid %b data %h want 1 %h", out_valid, out_data, {4{32'd16}});
    end
    handshake();
  endtask

  task automatic test_overflow();
    int got, cyc, w;
    logic [31:0] line_val, exp_lane0;
`ifdef ADDER_TREE_CTRL_SAT_EN
    // Each chunk sums to +0x40000000 in lane 0, so the second add overflows positive.
    line_val  = 32'h0800_0000;
    exp_lane0 = 32'h7FFF_FFFF;
`else
    line_val  = 32'h1000_0000;
    exp_lane0 = 32'h0000_0000;
`endif
    do_start(8'd2);
    feed_const(mk_chunk(line_val, 32'd0, 32'd0, 32'd0), 2, got, cyc);
    wait_valid(w);
    checks++; if (out_valid !== 1'b1 || out_data !== {96'd0, exp_lane0}) begin
      errors++; $display("FAIL overflow: valid %b data %h want 1 %h", out_valid, out_data, {96'd0, exp_lane0});
    end
    handshake();
  endtask

  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    cfg_len   = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_bubbles();
    test_zero_len();
    test_reset_mid();
    test_overflow();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
